// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED link receiver: opcodes, addressing
// modes, decoder states and framebuffer geometry.
package oled_pkg;

   localparam int COLS  = 128;
   localparam int PAGES = 8;

   localparam logic [6:0] COL_MAX  = 7'(COLS - 1);
   localparam logic [2:0] PAGE_MAX = 3'(PAGES - 1);

   localparam logic [7:0] CMD_CHARGE     = 8'h8D;
   localparam logic [7:0] CMD_ADDR_MODE  = 8'h20;
   localparam logic [7:0] CMD_CONTRAST   = 8'h81;
   localparam logic [7:0] CMD_PRECHARGE  = 8'hD9;
   localparam logic [7:0] CMD_COL_ADDR   = 8'h21;
   localparam logic [7:0] CMD_PAGE_ADDR  = 8'h22;
   localparam logic [7:0] CMD_DISP_ON    = 8'hAF;
   localparam logic [7:0] CMD_DISP_OFF   = 8'hAE;
   localparam logic [7:0] CMD_REMAP_ON   = 8'hA1;
   localparam logic [7:0] CMD_REMAP_OFF  = 8'hA0;
   localparam logic [7:0] CMD_SCAN_REV   = 8'hC8;
   localparam logic [7:0] CMD_SCAN_NORM  = 8'hC0;

   typedef enum logic [1:0] {
      AM_HORIZ = 2'b00,
      AM_VERT  = 2'b01,
      AM_PAGE  = 2'b10
   } addr_mode_e;

   typedef enum logic [1:0] {
      DEC_IDLE = 2'b00,
      DEC_ARG1 = 2'b01,
      DEC_ARG2 = 2'b10
   } dec_state_e;

   // Opcodes that are followed by at least one argument byte.
   function automatic logic has_arg(input logic [7:0] op);
      return (op == CMD_CHARGE)   || (op == CMD_ADDR_MODE) ||
             (op == CMD_CONTRAST) || (op == CMD_PRECHARGE) ||
             (op == CMD_COL_ADDR) || (op == CMD_PAGE_ADDR);
   endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling front end: synchronizes the serial pins, detects spi_clk rising
// edges and frames MSB-first bytes, dropping partial bytes after an idle gap.
module spi_byte_rx #(
   parameter int SYNC_STAGES  = 2,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_clk_i,
   input  logic       mosi_i,
   input  logic       dc_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_o,
   output logic       is_data_o
);

   localparam int IW = $clog2(IDLE_TIMEOUT + 1);

   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, dc_sync_q;
   logic                   sclk_prev_q;
   logic                   sclk_s, mosi_s, dc_s, rise;

   logic [6:0]    sr_q, sr_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [IW-1:0] idle_q, idle_d;
   logic          byte_valid_q, byte_valid_d;
   logic [7:0]    byte_q, byte_d;
   logic          is_data_q, is_data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         dc_sync_q   <= '0;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q[0] <= spi_clk_i;
         mosi_sync_q[0] <= mosi_i;
         dc_sync_q[0]   <= dc_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sclk_sync_q[i] <= sclk_sync_q[i-1];
            mosi_sync_q[i] <= mosi_sync_q[i-1];
            dc_sync_q[i]   <= dc_sync_q[i-1];
         end
         sclk_prev_q <= sclk_s;
      end
   end

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign dc_s   = dc_sync_q[SYNC_STAGES-1];
   assign rise   = sclk_s & ~sclk_prev_q;

   always_comb begin
      sr_d         = sr_q;
      bit_cnt_d    = bit_cnt_q;
      idle_d       = idle_q;
      byte_valid_d = 1'b0;
      byte_d       = byte_q;
      is_data_d    = is_data_q;
      if (rise) begin
         sr_d      = {sr_q[5:0], mosi_s};
         bit_cnt_d = bit_cnt_q + 3'd1;
         idle_d    = '0;
         if (bit_cnt_q == 3'd7) begin
            byte_valid_d = 1'b1;
            byte_d       = {sr_q, mosi_s};
            is_data_d    = dc_s;
         end
      end else if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
         // Idle counter saturates here and keeps the bit counter cleared.
         bit_cnt_d = '0;
      end else begin
         idle_d = idle_q + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q         <= '0;
         bit_cnt_q    <= '0;
         idle_q       <= '0;
         byte_valid_q <= 1'b0;
         byte_q       <= '0;
         is_data_q    <= 1'b0;
      end else begin
         sr_q         <= sr_d;
         bit_cnt_q    <= bit_cnt_d;
         idle_q       <= idle_d;
         byte_valid_q <= byte_valid_d;
         byte_q       <= byte_d;
         is_data_q    <= is_data_d;
      end
   end

   assign byte_valid_o = byte_valid_q;
   assign byte_o       = byte_q;
   assign is_data_o    = is_data_q;

endmodule

// File: rtl/oled_spi_rx.sv
// Display-side receiver for the 3-wire OLED link: decodes the SSD1306-style
// command set and turns data bytes into addressed framebuffer writes.
module oled_spi_rx
   import oled_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_clk,
   input  logic       mosi,
   input  logic       dc,
   output logic       wr_en,
   output logic [2:0] wr_page,
   output logic [6:0] wr_col,
   output logic [7:0] wr_data,
   output logic       cmd_valid,
   output logic [7:0] cmd_opcode,
   output logic       display_on,
   output logic       charge_pump_en,
   output logic [7:0] contrast,
   output logic [7:0] precharge,
   output logic       seg_remap,
   output logic       com_reverse,
   output logic [1:0] addr_mode,
   output logic       frame_done,
   output logic       proto_err
);

   logic       byte_valid, is_data;
   logic [7:0] rx_byte;

   spi_byte_rx #(
      .SYNC_STAGES (SYNC_STAGES),
      .IDLE_TIMEOUT(IDLE_TIMEOUT)
   ) u_byte_rx (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi_clk_i   (spi_clk),
      .mosi_i      (mosi),
      .dc_i        (dc),
      .byte_valid_o(byte_valid),
      .byte_o      (rx_byte),
      .is_data_o   (is_data)
   );

   dec_state_e state_q, state_d;
   logic [7:0] op_q, op_d;

   logic       wr_en_q, wr_en_d, cmd_valid_q, cmd_valid_d;
   logic       frame_done_q, frame_done_d, proto_err_q, proto_err_d;
   logic [2:0] wr_page_q, wr_page_d;
   logic [6:0] wr_col_q, wr_col_d;
   logic [7:0] wr_data_q, wr_data_d, cmd_opcode_q, cmd_opcode_d;
   logic       display_on_q, display_on_d, charge_q, charge_d;
   logic       seg_remap_q, seg_remap_d, com_rev_q, com_rev_d;
   logic [7:0] contrast_q, contrast_d, precharge_q, precharge_d;
   logic [1:0] addr_mode_q, addr_mode_d;

   logic [6:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
   logic [2:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;

   // A start beyond end never matches end, so the field maximum also wraps.
   logic       col_wrap, page_wrap;
   logic [6:0] col_next;
   logic [2:0] page_next;
   assign col_wrap  = (col_q == col_end_q) || (col_q == COL_MAX);
   assign page_wrap = (page_q == page_end_q) || (page_q == PAGE_MAX);
   assign col_next  = col_wrap ? col_start_q : col_q + 7'd1;
   assign page_next = page_wrap ? page_start_q : page_q + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= DEC_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (byte_valid) begin
         if (is_data) begin
            state_d = DEC_IDLE;
         end else begin
            case (state_q)
               DEC_IDLE: if (has_arg(rx_byte)) state_d = DEC_ARG1;
               DEC_ARG1: state_d = (op_q == CMD_COL_ADDR || op_q == CMD_PAGE_ADDR)
                                   ? DEC_ARG2 : DEC_IDLE;
               default:  state_d = DEC_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      op_d         = op_q;
      wr_en_d      = 1'b0;
      cmd_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      proto_err_d  = 1'b0;
      wr_page_d    = wr_page_q;
      wr_col_d     = wr_col_q;
      wr_data_d    = wr_data_q;
      cmd_opcode_d = cmd_opcode_q;
      display_on_d = display_on_q;
      charge_d     = charge_q;
      seg_remap_d  = seg_remap_q;
      com_rev_d    = com_rev_q;
      contrast_d   = contrast_q;
      precharge_d  = precharge_q;
      addr_mode_d  = addr_mode_q;
      col_d        = col_q;
      page_d       = page_q;
      col_start_d  = col_start_q;
      col_end_d    = col_end_q;
      page_start_d = page_start_q;
      page_end_d   = page_end_q;
      if (byte_valid && is_data) begin
         proto_err_d = (state_q != DEC_IDLE);
         wr_en_d     = 1'b1;
         wr_page_d   = page_q;
         wr_col_d    = col_q;
         wr_data_d   = rx_byte;
         case (addr_mode_q)
            AM_HORIZ: begin
               col_d = col_next;
               if (col_wrap) begin
                  page_d       = page_next;
                  frame_done_d = page_wrap;
               end
            end
            AM_VERT: begin
               page_d = page_next;
               if (page_wrap) begin
                  col_d        = col_next;
                  frame_done_d = col_wrap;
               end
            end
            default: col_d = col_next;
         endcase
      end else if (byte_valid) begin
         case (state_q)
            DEC_IDLE: begin
               op_d = rx_byte;
               if (!has_arg(rx_byte)) begin
                  cmd_valid_d  = 1'b1;
                  cmd_opcode_d = rx_byte;
                  case (rx_byte)
                     CMD_DISP_ON:   display_on_d = 1'b1;
                     CMD_DISP_OFF:  display_on_d = 1'b0;
                     CMD_REMAP_ON:  seg_remap_d  = 1'b1;
                     CMD_REMAP_OFF: seg_remap_d  = 1'b0;
                     CMD_SCAN_REV:  com_rev_d    = 1'b1;
                     CMD_SCAN_NORM: com_rev_d    = 1'b0;
                     default: ;
                  endcase
               end
            end
            DEC_ARG1: begin
               cmd_valid_d  = !(op_q == CMD_COL_ADDR || op_q == CMD_PAGE_ADDR);
               cmd_opcode_d = cmd_valid_d ? op_q : cmd_opcode_q;
               case (op_q)
                  CMD_CHARGE:    charge_d     = rx_byte[2];
                  CMD_ADDR_MODE: addr_mode_d  = rx_byte[1:0];
                  CMD_CONTRAST:  contrast_d   = rx_byte;
                  CMD_PRECHARGE: precharge_d  = rx_byte;
                  CMD_COL_ADDR:  col_start_d  = rx_byte[6:0];
                  CMD_PAGE_ADDR: page_start_d = rx_byte[2:0];
                  default: ;
               endcase
            end
            default: begin
               cmd_valid_d  = 1'b1;
               cmd_opcode_d = op_q;
               if (op_q == CMD_COL_ADDR) begin
                  col_end_d = rx_byte[6:0];
                  col_d     = col_start_q;
               end else begin
                  page_end_d = rx_byte[2:0];
                  page_d     = page_start_q;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q         <= '0;
         wr_en_q      <= 1'b0;
         cmd_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         proto_err_q  <= 1'b0;
         wr_page_q    <= '0;
         wr_col_q     <= '0;
         wr_data_q    <= '0;
         cmd_opcode_q <= '0;
         display_on_q <= 1'b0;
         charge_q     <= 1'b0;
         seg_remap_q  <= 1'b0;
         com_rev_q    <= 1'b0;
         contrast_q   <= 8'h7F;
         precharge_q  <= 8'h22;
         addr_mode_q  <= AM_PAGE;
         col_q        <= '0;
         page_q       <= '0;
         col_start_q  <= '0;
         col_end_q    <= COL_MAX;
         page_start_q <= '0;
         page_end_q   <= PAGE_MAX;
      end else begin
         op_q         <= op_d;
         wr_en_q      <= wr_en_d;
         cmd_valid_q  <= cmd_valid_d;
         frame_done_q <= frame_done_d;
         proto_err_q  <= proto_err_d;
         wr_page_q    <= wr_page_d;
         wr_col_q     <= wr_col_d;
         wr_data_q    <= wr_data_d;
         cmd_opcode_q <= cmd_opcode_d;
         display_on_q <= display_on_d;
         charge_q     <= charge_d;
         seg_remap_q  <= seg_remap_d;
         com_rev_q    <= com_rev_d;
         contrast_q   <= contrast_d;
         precharge_q  <= precharge_d;
         addr_mode_q  <= addr_mode_d;
         col_q        <= col_d;
         page_q       <= page_d;
         col_start_q  <= col_start_d;
         col_end_q    <= col_end_d;
         page_start_q <= page_start_d;
         page_end_q   <= page_end_d;
      end
   end

   assign wr_en          = wr_en_q;
   assign wr_page        = wr_page_q;
   assign wr_col         = wr_col_q;
   assign wr_data        = wr_data_q;
   assign cmd_valid      = cmd_valid_q;
   assign cmd_opcode     = cmd_opcode_q;
   assign display_on     = display_on_q;
   assign charge_pump_en = charge_q;
   assign contrast       = contrast_q;
   assign precharge      = precharge_q;
   assign seg_remap      = seg_remap_q;
   assign com_reverse    = com_rev_q;
   assign addr_mode      = addr_mode_q;
   assign frame_done     = frame_done_q;
   assign proto_err      = proto_err_q;

endmodule

// File: doc/oled_spi_rx.md
Name: oled_spi_rx

Overview:
- Display-side receiver for the 3-wire OLED link (spi_clk, mosi, dc) that our SPI master drives: the SSD1306-style command/data stream.
- Oversamples the link in the system clock domain, frames bytes, and decodes the command set the master emits: charge pump, addressing mode, contrast, precharge, remap, scan direction, display on/off, page/column window.
- Data bytes become framebuffer write strobes with auto-incremented page/column addresses.
- Used as an on-chip display model for loopback test and as the decode core of a future display emulator.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on spi_clk, mosi and dc.
- IDLE_TIMEOUT, 16, clk cycles with no spi_clk rising edge before the bit counter resets.

Ports:
- clk  input  1  system clock; must run at least 4x the spi_clk frequency.
- rst_n  input  1  asynchronous active-low reset.
- spi_clk  input  1  serial clock; mosi and dc are sampled on its rising edge.
- mosi  input  1  serial data, MSB first.
- dc  input  1  0 = command byte, 1 = data byte; sampled with bit 0 of each byte.
- wr_en  output  1  one-cycle framebuffer write strobe.
- wr_page  output  3  page address of the write.
- wr_col  output  7  column address of the write.
- wr_data  output  8  data byte of the write.
- cmd_valid  output  1  one-cycle pulse when a complete command, including its arguments, has been decoded.
- cmd_opcode  output  8  opcode of the last completed command.
- display_on  output  1  set by 0xAF, cleared by 0xAE.
- charge_pump_en  output  1  value of arg[2] of command 0x8D.
- contrast  output  8  value of the 0x81 argument.
- precharge  output  8  value of the 0xD9 argument.
- seg_remap  output  1  0xA1 sets it, 0xA0 clears it.
- com_reverse  output  1  0xC8 sets it, 0xC0 clears it.
- addr_mode  output  2  00 horizontal, 01 vertical, 10 page.
- frame_done  output  1  one-cycle pulse when the address pointer wraps to the window start.
- proto_err  output  1  one-cycle pulse when a pending command is aborted.

Behaviour:
- Reset values:
  - All strobes, wr_*, cmd_opcode, display_on, charge_pump_en, seg_remap and com_reverse are 0.
  - contrast = 0x7F, precharge = 0x22, addr_mode = 2'b10.
  - Window: col 0..127, page 0..7. Pointers: col 0, page 0. Bit counter 0. Decoder state IDLE.
- Reset is asynchronous. Asserting it mid-byte or mid-command discards everything in flight, with no strobe.
- Front end:
  - spi_clk, mosi and dc each pass through SYNC_STAGES flops.
  - Rising edge = synchronized spi_clk is 1 and its previous value was 0.
  - On each rising edge, shift mosi into sr[7:0] MSB first and increment the 3-bit bit counter.
  - On the 8th edge, latch {dc, byte} and raise byte_valid for one cycle. Latency is SYNC_STAGES+1 clk cycles after the pin edge.
- Idle resync: when no rising edge occurs for IDLE_TIMEOUT cycles, the bit counter clears and the partial byte is dropped silently.
- Data bytes (dc=1):
  - wr_en pulses the cycle after byte_valid, with the current pointers and the byte.
  - The pointer then advances as follows.
  - Horizontal (00): col++. At col_end, col = col_start and page++. At page_end, page = page_start and frame_done pulses in the same cycle as wr_en.
  - Vertical (01): page++. At page_end, page = page_start and col++. At col_end, col = col_start and frame_done pulses.
  - Page (10 or 11): col++. At col_end, col wraps to col_start; page is unchanged and frame_done does not pulse.
- Command decoder FSM states: IDLE, ARG1, ARG2.
  - IDLE, command byte:
    - One-argument opcodes 0x8D, 0x20, 0x81, 0xD9 latch the opcode and go to ARG1.
    - Two-argument opcodes 0x21, 0x22 go to ARG1.
    - All other opcodes execute immediately and pulse cmd_valid. Unknown opcodes pulse cmd_valid and change no register.
  - ARG1:
    - One-argument command: apply the argument, pulse cmd_valid, go to IDLE.
    - 0x21: latch col_start = arg[6:0], go to ARG2.
    - 0x22: latch page_start = arg[2:0], go to ARG2.
  - ARG2:
    - 0x21: col_end = arg[6:0], col pointer = col_start.
    - 0x22: page_end = arg[2:0], page pointer = page_start.
    - Then pulse cmd_valid and go to IDLE.
  - 0x20 writes addr_mode = arg[1:0].
- Window checks: a start greater than end is legal. The pointer then runs start..max and never matches end, so wrap occurs at the field maximum (127 or 7).
- Data byte while in ARG1 or ARG2:
  - pulse proto_err;
  - return to IDLE with no register update;
  - process the byte as a normal data write in the same cycle.
- Simultaneous events: an argument-complete update and a data write cannot coincide, because bytes are serialized. A pointer update from 0x21/0x22 takes effect before the next data byte.

Decomposition:
- Shared package oled_pkg holds:
  - opcode constants: CMD_CHARGE 8'h8D, CMD_ADDR_MODE 8'h20, CMD_CONTRAST 8'h81, CMD_PRECHARGE 8'hD9, CMD_COL_ADDR 8'h21, CMD_PAGE_ADDR 8'h22, CMD_DISP_ON 8'hAF, CMD_DISP_OFF 8'hAE, remap and scan opcodes;
  - the addr_mode enum;
  - the decoder state enum;
  - COLS = 128 and PAGES = 8.
- One sub-module, spi_byte_rx: the synchronizers, edge detect, shift register, bit counter and idle timeout. It outputs byte_valid, byte and is_data.
- The top level holds the decoder FSM and the address generator.

Test Plan:
- Master power-up sequence 8D 14, 20 00, 81 CF, D9 F1, A1, C8, A4, AF -> eight cmd_valid pulses; then charge_pump_en=1, addr_mode=00, contrast=CF, precharge=F1, seg_remap=1, com_reverse=1, display_on=1.
- 22 00 FF, 21 00 7F, then 1024 data bytes with value = index[7:0] -> writes sweep page 0 col 0..127 through page 7; wr_data matches; exactly one frame_done, on write 1024; write 1025 lands at page 0 col 0.
- 21 10 13, 22 02 03, horizontal mode, 9 data bytes -> addresses (2,16..19), (3,16..19), then (2,16) with frame_done on byte 8.
- Command 81, then a data byte AA -> proto_err pulse; contrast unchanged at 7F; write of AA at the current pointer; decoder back in IDLE.
- 3 spi_clk edges, a gap of IDLE_TIMEOUT+2 cycles, then the full byte AF -> only one byte decoded (display_on=1); no spurious strobe.
- Assert rst_n low after 5 bits of a data byte -> no wr_en; all outputs at their reset values asynchronously.
